fp8_divider: RTL and testbench
==============================

FP8_DIVIDER -- requirements
Module: fp8_divider

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 7, FP8 exponent bias.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  divider idle; offer accepted on clk edge with in_valid=1.
REQ-006 SHALL have port a  input  8  dividend, FP8 {sign[7], exp[6:3], mant[2:0]}.
REQ-007 SHALL have port b  input  8  divisor, same format.
REQ-008 SHALL have port out_valid  output  1  quotient available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts quotient.
REQ-010 SHALL have port quotient  output  8  FP8 result a/b.
REQ-011 SHALL have port ovf  output  1  true exponent above 15, field wrapped.
REQ-012 SHALL have port unf  output  1  true exponent below 0, field wrapped.

Function
REQ-013 SHALL treat every encoding as normal with implicit leading 1: value = (-1)^s * 1.mant * 2^(exp-EXP_BIAS); no zero, inf, NaN or subnormal codes.
REQ-014 SHALL latch a and b on the edge where in_valid and in_ready are both 1; later input changes are ignored.
REQ-015 SHALL assert in_ready only in state IDLE.
REQ-016 SHALL implement states IDLE -> DIV (accept) -> NORM (after 5 DIV cycles) -> DONE (after 1 NORM cycle) -> IDLE (out_valid and out_ready both 1).
REQ-017 SHALL, in DIV, run a restoring mantissa division of MA={1,mant_a} by MB={1,mant_b}, one quotient bit per cycle, MSB first, remainder 5 bits wide, initial remainder MA.
REQ-018 SHALL produce Q = floor(MA*16/MB), 5 bits, range 8..30, after 5 DIV cycles.
REQ-019 SHALL in NORM set mant = Q[3:1] when Q[4]=1, else Q[2:0]; truncate, no rounding.
REQ-020 SHALL compute true exponent E = exp_a - exp_b + EXP_BIAS - (Q[4] ? 0 : 1) in signed 6-bit arithmetic, range -9..22.
REQ-021 SHALL set quotient = {sign_a XOR sign_b, E[3:0], mant}, ovf = (E>15), unf = (E<0), all registered in NORM.
REQ-022 SHALL assert out_valid in DONE only; out_valid rises on the 6th clk edge after the accept edge.
REQ-023 SHALL hold quotient, ovf and unf stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-024 SHALL leave quotient, ovf and unf at last values after handshake until the next NORM.
REQ-025 SHALL ignore in_valid outside IDLE; throughput is at most one operation per 8 cycles.

Reset
REQ-026 SHALL on rst_n=0 immediately set state IDLE, out_valid=0, quotient=8'h00, ovf=0, unf=0, remainder/quotient/operand registers 0.
REQ-027 SHALL abort any operation in progress on reset; no result is delivered for it.
REQ-028 SHALL present in_ready=1 in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL take FP8 field widths/positions, EXP_BIAS default and the state enumeration from shared package fp8_pkg.
REQ-030 SHALL place the iterative restoring mantissa divider in one sub-module, mant_divider (start, 5-cycle busy, done, Q output); FSM, exponent and sign logic stay in fp8_divider.

Verification
REQ-031 SHALL verify a=0x38, b=0x38 -> quotient=0x38, ovf=0, unf=0, out_valid exactly 6 edges after accept.
REQ-032 SHALL verify a=0x3C, b=0x3A (MA=12, MB=10, Q=19) -> quotient=0x39; a=0xB8, b=0x3F (Q=8) -> quotient=0xB0.
REQ-033 SHALL verify a=0x78, b=0x00 (E=22) -> quotient=0x30, ovf=1; a=0x00, b=0x7F (E=-9) -> quotient=0x38, unf=1.
REQ-034 SHALL verify out_ready=0 for 10 cycles in DONE -> out_valid, quotient, flags stable, in_ready=0, second in_valid pulse ignored.
REQ-035 SHALL verify rst_n pulsed low during DIV cycle 3 -> out_valid=0 immediately, in_ready=1 after release, next operation a=0x38, b=0x38 returns 0x38.
REQ-036 SHALL verify random normal operands against a reference model of REQ-018..021, including Q[4]=0 and Q[4]=1 cases.

Source files
------------

// File: rtl/fp8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp8_pkg
// Brief    : FP8 field layout, default exponent bias and divider FSM states.
// Revision : 1.0
// ============================================================================
package fp8_pkg;

    localparam int c_sign_bit      = 7;
    localparam int c_exp_msb       = 6;
    localparam int c_exp_lsb       = 3;
    localparam int c_mant_msb      = 2;
    localparam int c_def_exp_bias  = 7;
    localparam int c_div_cycles    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [3:0] full_mant(input logic [c_mant_msb:0] m);
        return {1'b1, m};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp8_divider_mant_divider.sv
`default_nettype none
// ============================================================================
// Module   : mant_divider
// Brief    : Restoring 4-bit mantissa divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module mant_divider
    import fp8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [3:0] i_ma,
    input  logic [3:0] i_mb,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_q
);

    logic [4:0] r_rem;
    logic [3:0] r_mb;
    logic [4:0] r_q;
    logic [2:0] r_cnt;

    logic       w_ge;
    logic [4:0] w_rem_sub;

    assign w_ge      = (r_rem >= {1'b0, r_mb});
    // After a restore the remainder is below MB, so 4 bits survive the shift
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= 5'd0;
            r_mb  <= 4'd0;
            r_q   <= 5'd0;
            r_cnt <= 3'd0;
        end else if (i_start) begin
            r_rem <= {1'b0, i_ma};
            r_mb  <= i_mb;
            r_q   <= 5'd0;
            r_cnt <= 3'(c_div_cycles);
        end else if (r_cnt != 3'd0) begin
            r_q   <= {r_q[3:0], w_ge};
            r_rem <= {w_rem_sub[3:0], 1'b0};
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_busy = (r_cnt != 3'd0);
    assign o_done = (r_cnt == 3'd1);
    assign o_q    = r_q;

endmodule
`default_nettype wire

// File: rtl/fp8_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp8_divider
// Brief    : Multi-cycle FP8 divider with valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module fp8_divider
    import fp8_pkg::*;
#(
    parameter int EXP_BIAS = c_def_exp_bias
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] quotient,
    output logic       ovf,
    output logic       unf
);

    state_t     r_state;
    state_t     w_state_nxt;

    // Sign and exponent of each operand; mantissas live in the divider
    logic [4:0] r_a_se;
    logic [4:0] r_b_se;
    logic [7:0] r_quotient;
    logic       r_ovf;
    logic       r_unf;

    logic       w_accept;
    logic       w_div_busy;
    logic       w_div_done;
    logic [4:0] w_q;
    logic [5:0] w_exp;
    logic [2:0] w_mant;

    assign w_accept = in_valid && (r_state == IDLE);

    mant_divider u_mant_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_accept),
        .i_ma    (full_mant(a[c_mant_msb:0])),
        .i_mb    (full_mant(b[c_mant_msb:0])),
        .o_busy  (w_div_busy),
        .o_done  (w_div_done),
        .o_q     (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid)              w_state_nxt = DIV;
            DIV: begin
                if (w_div_done)              w_state_nxt = NORM;
                else if (!w_div_busy)        w_state_nxt = IDLE;
            end
            NORM:                            w_state_nxt = DONE;
            DONE: if (out_ready)             w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    // Six-bit two's complement covers the full -9..22 exponent span
    assign w_exp  = {2'b00, r_a_se[3:0]} - {2'b00, r_b_se[3:0]}
                  + 6'(EXP_BIAS) - {5'd0, ~w_q[4]};
    assign w_mant = w_q[4] ? w_q[3:1] : w_q[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_se     <= 5'd0;
            r_b_se     <= 5'd0;
            r_quotient <= 8'h00;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_se <= {a[c_sign_bit], a[c_exp_msb:c_exp_lsb]};
                r_b_se <= {b[c_sign_bit], b[c_exp_msb:c_exp_lsb]};
            end
            if (r_state == NORM) begin
                r_quotient <= {r_a_se[4] ^ r_b_se[4], w_exp[3:0], w_mant};
                r_ovf      <= ~w_exp[5] & w_exp[4];
                r_unf      <= w_exp[5];
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp8_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp8_divider
// Brief    : Directed and random self-checking bench for fp8_divider.
// Revision : 1.0
// ============================================================================
module tb_fp8_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic       ovf;
    logic       unf;

    int checks   = 0;
    int failures = 0;

    fp8_divider #(.EXP_BIAS(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, unf, quotient}
    function automatic logic [9:0] ref_div(input logic [7:0] x, input logic [7:0] y);
        int ma, mb, q, e;
        logic [2:0] m;
        logic [3:0] ef;
        ma = 8 + int'(x[2:0]);
        mb = 8 + int'(y[2:0]);
        q  = (ma * 16) / mb;
        e  = int'(x[6:3]) - int'(y[6:3]) + 7 - ((q >= 16) ? 0 : 1);
        m  = (q >= 16) ? 3'((q >> 1) & 7) : 3'(q & 7);
        ef = 4'(e & 15);
        return {(e > 15), (e < 0), x[7] ^ y[7], ef, m};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] eq,
                          input logic eo, input logic eu, input logic hs, input string tag);
        int n;
        @(negedge clk);
        a = ta; b = tb; in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = 8'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd6);
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        check({tag, "_unf"}, 32'(unf), 32'(eu));
        if (hs) begin
            @(posedge clk); #1;
            check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
        end
    endtask

    initial begin
        logic [9:0] r;
        logic [7:0] ra, rb;
        int q4_hi, q4_lo;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00;
        #1;
        check("rst_quotient", 32'(quotient), 32'h00);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 1'b1, "one");
        run_op(8'h3C, 8'h3A, 8'h39, 1'b0, 1'b0, 1'b1, "q19");
        run_op(8'hB8, 8'h3F, 8'hB0, 1'b0, 1'b0, 1'b1, "q8_neg");
        run_op(8'h78, 8'h00, 8'h30, 1'b1, 1'b0, 1'b1, "ovf");
        run_op(8'h00, 8'h7F, 8'h38, 1'b0, 1'b1, 1'b1, "unf");

        // Consumer stall with an extra offer that must be ignored
        out_ready = 1'b0;
        run_op(8'h3C, 8'h3A, 8'h39, 1'b0, 1'b0, 1'b0, "stall");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 3); a = 8'h78; b = 8'h00;
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_quotient", 32'(quotient), 32'h39);
            check("stall_flags", 32'({ovf, unf}), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", 32'(out_valid), 32'd0);
        check("stall_release_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("stall_no_ghost", 32'(out_valid), 32'd0);
        end

        // Abort during the third DIV cycle
        @(negedge clk); a = 8'h3C; b = 8'h3A; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_quotient", 32'(quotient), 32'h00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 1'b1, "after_abort");

        q4_hi = 0; q4_lo = 0;
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            if (ra[2:0] >= rb[2:0]) q4_hi++; else q4_lo++;
            r = ref_div(ra, rb);
            run_op(ra, rb, r[7:0], r[9], r[8], 1'b1, "rand");
        end
        $display("random ops: Q4=1 %0d, Q4=0 %0d", q4_hi, q4_lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
